// File: rtl/tt_um_jimktrains_vslc_fetcher.sv
// Program store and scan sequencer for the VSLC executor: bit-serial program load
// into a small RAM, then cyclic replay of the program with per-scan input snapshots.
module tt_um_jimktrains_vslc_fetcher #(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              sclk,
  input  logic              sdata,
  input  logic              run_en,
  input  logic [7:0]        ui_in,
  output logic [7:0]        instr,
  output logic              instr_ready,
  output logic [7:0]        ui_scan,
  output logic [7:0]        ui_prev,
  output logic [15:0]       counter,
  output logic [ADDR_W:0]   prog_len,
  output logic              scan_done,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ZERO_C  = (ADDR_W+1)'(0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_SCAN  = 3'd3,
    ST_END   = 3'd4
  } state_t;

  state_t          state_r;
  logic [7:0]      mem_r [PROG_DEPTH];
  logic [2:0]      load_en_sync_r;
  logic [2:0]      sclk_sync_r;
  logic [1:0]      sdata_sync_r;
  logic [ADDR_W:0] load_ptr_r;
  logic [ADDR_W:0] pc_r;
  logic [2:0]      bit_cnt_r;
  logic [6:0]      shift_r;
  logic [7:0]      byte_r;
  logic            byte_vld_r;

  logic            load_rise_s;
  logic            load_fall_s;
  logic            sclk_rise_s;
  logic            sdata_s;
  logic            wr_en_s;

  // Bit [1] is the synchronized level, bit [2] its one-cycle history for edge detection.
  assign load_rise_s = load_en_sync_r[1] & ~load_en_sync_r[2];
  assign load_fall_s = ~load_en_sync_r[1] & load_en_sync_r[2];
  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
  assign sdata_s     = sdata_sync_r[1];
  assign wr_en_s     = (state_r == ST_LOAD) && byte_vld_r && (load_ptr_r != DEPTH_C);

  // Synchronizers for the asynchronous load port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_en_sync_r <= 3'd0;
      sclk_sync_r    <= 3'd0;
      sdata_sync_r   <= 2'd0;
    end else begin
      load_en_sync_r <= {load_en_sync_r[1:0], load_en};
      sclk_sync_r    <= {sclk_sync_r[1:0], sclk};
      sdata_sync_r   <= {sdata_sync_r[0], sdata};
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= 16'd0;
    end else begin
      counter <= counter + 16'd1;
    end
  end

  // Program RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[load_ptr_r[ADDR_W-1:0]] <= byte_r;
    end
  end

  // Load / scan sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      instr       <= 8'd0;
      instr_ready <= 1'b0;
      ui_scan     <= 8'd0;
      ui_prev     <= 8'd0;
      prog_len    <= ZERO_C;
      scan_done   <= 1'b0;
      overflow    <= 1'b0;
      load_ptr_r  <= ZERO_C;
      pc_r        <= ZERO_C;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 7'd0;
      byte_r      <= 8'd0;
      byte_vld_r  <= 1'b0;
    end else begin
      scan_done  <= 1'b0;
      byte_vld_r <= 1'b0;
      if (load_rise_s) begin
        state_r     <= ST_LOAD;
        load_ptr_r  <= ZERO_C;
        bit_cnt_r   <= 3'd0;
        overflow    <= 1'b0;
        instr_ready <= 1'b0;
      end else begin
        case (state_r)
          ST_LOAD: begin
            instr_ready <= 1'b0;
            if (load_fall_s) begin
              prog_len  <= load_ptr_r;
              bit_cnt_r <= 3'd0;
              state_r   <= ST_IDLE;
            end else begin
              if (sclk_rise_s) begin
                shift_r   <= {shift_r[5:0], sdata_s};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                  byte_r     <= {shift_r, sdata_s};
                  byte_vld_r <= 1'b1;
                end
              end
              // A completed byte is committed one cycle later; past the end it only flags.
              if (byte_vld_r) begin
                if (load_ptr_r == DEPTH_C) begin
                  overflow <= 1'b1;
                end else begin
                  load_ptr_r <= load_ptr_r + ONE_C;
                end
              end
            end
          end
          ST_IDLE: begin
            instr_ready <= 1'b0;
            if (run_en && (prog_len != ZERO_C)) begin
              state_r <= ST_START;
            end
          end
          ST_START: begin
            ui_prev     <= ui_scan;
            ui_scan     <= ui_in;
            pc_r        <= ZERO_C;
            instr_ready <= 1'b0;
            state_r     <= ST_SCAN;
          end
          ST_SCAN: begin
            instr       <= mem_r[pc_r[ADDR_W-1:0]];
            instr_ready <= 1'b1;
            pc_r        <= pc_r + ONE_C;
            if (pc_r == (prog_len - ONE_C)) begin
              state_r <= ST_END;
            end
          end
          ST_END: begin
            instr_ready <= 1'b0;
            scan_done   <= 1'b1;
            state_r     <= run_en ? ST_START : ST_IDLE;
          end
          default: begin
            instr_ready <= 1'b0;
            state_r     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_fetcher.sv
// Directed bench for the VSLC fetcher: a scan-phase model checked every cycle,
// plus hand-computed literal expectations for load, scan, abort, reset and wrap.
module tb_tt_um_jimktrains_vslc_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic        sclk = 1'b0;
  logic        sdata = 1'b0;
  logic        run_en = 1'b0;
  logic [7:0]  ui_in = 8'd0;
  logic [7:0]  instr;
  logic        instr_ready;
  logic [7:0]  ui_scan;
  logic [7:0]  ui_prev;
  logic [15:0] counter;
  logic [5:0]  prog_len;
  logic        scan_done;
  logic        overflow;

  always #5 clk = ~clk;

  tt_um_jimktrains_vslc_fetcher #(.PROG_DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .sclk(sclk), .sdata(sdata),
    .run_en(run_en), .ui_in(ui_in), .instr(instr), .instr_ready(instr_ready),
    .ui_scan(ui_scan), .ui_prev(ui_prev), .counter(counter), .prog_len(prog_len),
    .scan_done(scan_done), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  // Model inputs owned by the stimulus process.
  logic       m_on = 1'b0;
  int         m_len = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_prog [64];
  logic [7:0] ld_data [64];

  // Model state: m_k is the scan phase visible on the outputs.
  // -1 idle, -2 start pending, 0 snapshot cycle, 1..len byte k-1, len+1 scan_done.
  int         m_k;
  logic       m_nxt;
  logic [15:0] m_cnt;
  logic [7:0] m_ui_scan;
  logic [7:0] m_ui_prev;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt <= 16'd0; m_k <= -1; m_nxt <= 1'b0;
      m_ui_scan <= 8'd0; m_ui_prev <= 8'd0;
    end else begin
      m_cnt <= m_cnt + 16'd1;
      if (!m_on) begin
        m_k <= -1;
      end else if (m_k == -1) begin
        if (run_en && m_len != 0) m_k <= -2;
      end else if (m_k == -2) begin
        m_k <= 0; m_ui_prev <= m_ui_scan; m_ui_scan <= ui_in;
      end else if (m_k <= m_len) begin
        if (m_k == m_len) m_nxt <= run_en;
        m_k <= m_k + 1;
      end else if (m_nxt) begin
        m_k <= 0; m_ui_prev <= m_ui_scan; m_ui_scan <= ui_in;
      end else begin
        m_k <= -1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    logic e_rdy, e_done;
    if (rst_n) begin
      chk("counter", 32'(counter), 32'(m_cnt));
      if (m_on) begin
        e_rdy  = (m_k >= 1) && (m_k <= m_len);
        e_done = (m_k == m_len + 1);
        chk("instr_ready", 32'(instr_ready), 32'(e_rdy));
        chk("scan_done", 32'(scan_done), 32'(e_done));
        chk("prog_len", 32'(prog_len), 32'(m_len));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("ui_scan", 32'(ui_scan), 32'(m_ui_scan));
        chk("ui_prev", 32'(ui_prev), 32'(m_ui_prev));
        if (e_rdy) chk("instr", 32'(instr), 32'(m_prog[m_k-1]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_cmp();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sdata = b[7-i];
      sclk = 1'b0;
      repeat (4) tick();
      sclk = 1'b1;
      repeat (4) tick();
    end
  endtask

  task automatic start_load();
    m_on = 1'b0;
    load_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) chk("load_rdy_low", 32'(instr_ready), 32'd0);
    end
  endtask

  task automatic end_load(input int n);
    repeat (6) tick();
    load_en = 1'b0;
    repeat (3) tick();
    m_len = (n > 32) ? 32 : n;
    m_ovf = (n > 32);
    for (int i = 0; i < m_len; i++) m_prog[i] = ld_data[i];
    m_on = 1'b1;
  endtask

  logic [7:0] pat_instr [5];
  logic       pat_rdy [5];
  logic       pat_done [5];

  initial begin
    int rc, dc, found;
    logic [7:0] last;

    pat_instr[0] = 8'h00; pat_instr[1] = 8'h00; pat_instr[2] = 8'h88;
    pat_instr[3] = 8'hB3; pat_instr[4] = 8'h00;
    pat_rdy[0] = 1'b0; pat_rdy[1] = 1'b1; pat_rdy[2] = 1'b1; pat_rdy[3] = 1'b1; pat_rdy[4] = 1'b0;
    pat_done[0] = 1'b0; pat_done[1] = 1'b0; pat_done[2] = 1'b0; pat_done[3] = 1'b0; pat_done[4] = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_ui_scan", 32'(ui_scan), 32'd0);
    chk("rst_ui_prev", 32'(ui_prev), 32'd0);
    chk("rst_counter", 32'(counter), 32'd0);
    chk("rst_prog_len", 32'(prog_len), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    m_on = 1'b1;

    // Empty program: run_en must not start a scan.
    run_en = 1'b1;
    rc = 0;
    repeat (10) begin tick(); rc += int'(instr_ready); end
    chk("len0_no_ready", 32'(rc), 32'd0);
    run_en = 1'b0;

    // Three-byte program and the scan/snapshot pattern.
    ld_data[0] = 8'h00; ld_data[1] = 8'h88; ld_data[2] = 8'hB3;
    start_load();
    for (int i = 0; i < 3; i++) send_bits(ld_data[i], 8);
    end_load(3);
    chk("len3_prog_len", 32'(prog_len), 32'd3);
    chk("len3_overflow", 32'(overflow), 32'd0);
    ui_in = 8'h01;
    run_en = 1'b1;
    tick(); tick();
    chk("scan1_ui_scan", 32'(ui_scan), 32'h01);
    chk("scan1_ui_prev", 32'(ui_prev), 32'h00);
    ui_in = 8'h03;
    repeat (5) tick();
    chk("scan2_ui_scan", 32'(ui_scan), 32'h03);
    chk("scan2_ui_prev", 32'(ui_prev), 32'h01);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) tick();
      chk("pat_ready", 32'(instr_ready), 32'(pat_rdy[j]));
      chk("pat_done", 32'(scan_done), 32'(pat_done[j]));
      if (pat_rdy[j]) chk("pat_instr", 32'(instr), 32'(pat_instr[j]));
    end

    // Drop run_en while pc=1 is on the bus: scan completes, then idle.
    tick(); tick(); tick();
    chk("pc1_instr", 32'(instr), 32'h88);
    run_en = 1'b0;
    rc = 0; dc = 0;
    repeat (12) begin tick(); rc += int'(instr_ready); dc += int'(scan_done); end
    chk("drop_ready_cnt", 32'(rc), 32'd1);
    chk("drop_done_cnt", 32'(dc), 32'd1);
    repeat (5) tick();

    // Load-abort mid-scan, reloading with 12 bits.
    for (int i = 0; i < 8; i++) ld_data[i] = 8'(8'h10 + i);
    start_load();
    for (int i = 0; i < 8; i++) send_bits(ld_data[i], 8);
    end_load(8);
    run_en = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      tick();
      if (instr_ready && instr == 8'h11) found = 1;
    end
    chk("abort_reach", 32'(found), 32'd1);
    ld_data[0] = 8'h5A; ld_data[1] = 8'hF0;
    start_load();
    send_bits(8'h5A, 8);
    send_bits(8'hF0, 4);
    end_load(1);
    chk("part_prog_len", 32'(prog_len), 32'd1);
    rc = 0;
    repeat (12) begin tick(); rc += int'(instr_ready); end
    chk("len1_ready_cnt", 32'(rc), 32'd4);
    run_en = 1'b0;
    repeat (6) tick();

    // 33 bytes into a 32-byte store.
    for (int i = 0; i < 33; i++) ld_data[i] = 8'(i * 37 + 5);
    start_load();
    for (int i = 0; i < 33; i++) send_bits(ld_data[i], 8);
    end_load(33);
    chk("ovf_prog_len", 32'(prog_len), 32'd32);
    chk("ovf_flag", 32'(overflow), 32'd1);
    run_en = 1'b1;
    last = 8'd0; found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      tick();
      if (instr_ready) last = instr;
      if (scan_done) found = 1;
    end
    chk("ovf_scan_done", 32'(found), 32'd1);
    chk("ovf_mem31", 32'(last), 32'h80);

    // Asynchronous reset in the middle of a scan.
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick();
      if (instr_ready) found = 1;
    end
    chk("rst_mid_scan", 32'(found), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_on = 1'b0;
    #1;
    chk("arst_ready", 32'(instr_ready), 32'd0);
    chk("arst_done", 32'(scan_done), 32'd0);
    chk("arst_counter", 32'(counter), 32'd0);
    chk("arst_prog_len", 32'(prog_len), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    m_len = 0; m_ovf = 1'b0;
    m_on = 1'b1;

    // Counter wrap; run_en stays high but the store is empty so nothing issues.
    repeat (65535) tick();
    chk("counter_max", 32'(counter), 32'h0000FFFF);
    tick();
    chk("counter_wrap", 32'(counter), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_jimktrains_vslc_fetcher.md
# tt_um_jimktrains_vslc_fetcher

Program store and instruction sequencer feeding the VSLC executor. Bytes arrive over a slow bit-serial load port and are stored in an on-chip program RAM. In run mode the block replays the program as a repeating scan cycle: it drives `instr`/`instr_ready` to the executor and supplies the per-scan input snapshot (`ui_scan`, `ui_prev`) plus the free-running `counter` the executor's timer and servo dividers tap.

## Interface
- `PROG_DEPTH`, 32: program bytes; power of two, 2..64.
- `ADDR_W`, 5: `log2(PROG_DEPTH)`.
- `clk` in 1: single clock; all state on posedge.
- `rst_n` in 1: asynchronous active-low reset.
- `load_en` in 1: high = load mode; level-sensitive, synchronized internally.
- `sclk` in 1: serial load clock, async to `clk`; data sampled on rising edge.
- `sdata` in 1: serial load data, MSB first.
- `run_en` in 1: enables scanning when `load_en` is low.
- `ui_in` in 8: raw inputs.
- `instr` out 8: current program byte.
- `instr_ready` out 1: `instr` valid this cycle.
- `ui_scan` out 8: inputs latched at scan start.
- `ui_prev` out 8: `ui_scan` of the previous scan.
- `counter` out 16: free-running cycle counter.
- `prog_len` out ADDR_W+1: bytes in the stored program.
- `scan_done` out 1: one-cycle pulse at end of each scan.
- `overflow` out 1: sticky; load tried to write past `PROG_DEPTH`.

## Operation
- Reset values: `instr`=0, `instr_ready`=0, `ui_scan`=0, `ui_prev`=0, `counter`=0, `prog_len`=0, `scan_done`=0, `overflow`=0, state IDLE. RAM contents are not reset.
- `counter` increments every cycle and wraps at 0xFFFF→0. It never stops.
- `load_en`, `sclk` and `sdata` pass through 2-flop synchronizers. An `sclk` rising edge is detected from the synced history.
- **LOAD** (entered from any state on synced `load_en` rise):
  - `load_ptr`, bit count and `overflow` clear to 0.
  - Each `sclk` rise shifts `sdata` in MSB first.
  - On the 8th bit, the byte is written to `mem[load_ptr]` and `load_ptr` increments.
  - If `load_ptr`=`PROG_DEPTH`, the write is dropped, `overflow` is set, and `load_ptr` saturates.
  - On synced `load_en` fall: `prog_len` ← `load_ptr`, any partial byte is discarded, go to IDLE.
- **IDLE**: `instr_ready`=0. Go to START when `run_en` is high and `prog_len`≠0.
- **START** (1 cycle): `ui_prev` ← `ui_scan`, `ui_scan` ← `ui_in`, `pc` ← 0, `instr_ready`=0. Go to SCAN.
- **SCAN**: each cycle, `instr` ← `mem[pc]`, `instr_ready` ← 1, `pc`++.
  - After issuing `pc`=`prog_len`−1, go to END.
  - Operand bytes (following a SPARAM opcode) are streamed like any other byte; the executor tracks operand state itself.
- **END** (1 cycle): `instr_ready`=0, `scan_done`=1.
  - Go to START if `run_en` is high, else IDLE.
- **Abort rules:**
  - `run_en` low during SCAN: the current scan completes, then IDLE.
  - `load_en` rise during SCAN: immediate LOAD; `instr_ready` is 0 from the next cycle.

## Timing
- Registered outputs change on posedge only. The executor samples on negedge, so it sees `instr` stable for half a cycle on each side.
- Scan period = `prog_len` + 2 cycles: one START cycle, `prog_len` SCAN cycles, one END cycle.
- `instr_ready` is high for exactly `prog_len` consecutive cycles per scan.
- `ui_scan` and `ui_prev` are stable throughout SCAN.
- Load constraint: `sclk` high and low phases ≥ 3 `clk` cycles each. `sdata` must be stable around the `sclk` rise.
- Load-edge latency: RAM write occurs 4 cycles after the 8th `sclk` rise at the pin. The `load_en` transition takes effect 3 cycles after the pin transition.
- `prog_len` updates in the same cycle LOAD exits.
- Reset asserted mid-scan or mid-load: all outputs take their reset values immediately (asynchronously); the partial load is lost.

## Test plan
- Load 3 bytes 0x00, 0x88, 0xB3, then `run_en`=1 → `prog_len`=3. Repeating pattern: START (`instr_ready`=0), `instr` 0x00/0x88/0xB3 with `instr_ready`=1, END with `scan_done`=1. Period = 5 cycles.
- `ui_in`=0x01 during the first START, 0x03 during the second → after the second START, `ui_scan`=0x03 and `ui_prev`=0x01.
- Load 33 bytes with `PROG_DEPTH`=32 → `prog_len`=32, `overflow`=1, `mem[31]` = 32nd byte. Load 12 bits → `prog_len`=1; the partial byte is discarded.
- Drop `run_en` mid-scan at `pc`=1 of 3 → the remaining bytes issue, then `scan_done`, then IDLE with no further `instr_ready`. Raise `load_en` mid-scan instead → `instr_ready`=0 within 4 cycles of the pin edge.
- `prog_len`=0 with `run_en`=1 → stays IDLE, `instr_ready` never asserted. `counter` is preloaded via 65535 cycles after reset, then wraps to 0.
- Assert `rst_n`=0 asynchronously mid-SCAN → `instr_ready`, `scan_done` and `counter` are 0 before the next posedge. After release, state is IDLE.
